// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and default widths for the branch resolve queue
package branch_pkg;

    localparam int BRQ_ADDR_W = 1;
    localparam int BRQ_CNT_W  = 16;

    typedef struct packed {
        logic [BRQ_ADDR_W-1:0] addr;
        logic                  pred;
    } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// rtl/branch_resolve_queue_if.sv - issue/resolve/training handshake bundle
interface branch_resolve_queue_if #(parameter int ADDR_W = 1);

    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_address;
    logic              issue_prediction;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_address;
    logic              upd_result;

    modport master (
        output issue_valid, issue_address, issue_prediction, resolve_valid, resolve_taken,
        input  issue_ready, upd_valid, upd_address, upd_result
    );

    modport slave (
        input  issue_valid, issue_address, issue_prediction, resolve_valid, resolve_taken,
        output issue_ready, upd_valid, upd_address, upd_result
    );

endinterface

// File: rtl/brq_fifo.sv
// rtl/brq_fifo.sv - in-order entry storage with occupancy count and synchronous clear
module brq_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  brq_entry_t             wdata_i,
    output brq_entry_t             rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    brq_entry_t           mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (!push_i && pop_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - predictor-to-resolution queue: training, mispredict flush, stats
// Hit/miss counters are built only when BRQ_STATS_EN is defined.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int ADDR_W = BRQ_ADDR_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = BRQ_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_resolve_queue_if.slave  bus,
    output logic                   mispredict,
    output logic                   resolve_err,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0] count;
    brq_entry_t    head, wentry;
    logic          ready, do_pop, do_miss, do_push;

    logic              upd_valid_q, upd_valid_d;
    logic [ADDR_W-1:0] upd_address_q, upd_address_d;
    logic              upd_result_q, upd_result_d;
    logic              mispredict_q, mispredict_d;
    logic              resolve_err_q, resolve_err_d;

    // Ready depends only on occupancy so it never combinationally follows resolve.
    assign ready   = (count != FULL_CNT);
    assign do_pop  = bus.resolve_valid && (count != '0);
    assign do_miss = do_pop && (head.pred != bus.resolve_taken);
    assign do_push = bus.issue_valid && ready && !do_miss;
    assign wentry  = '{addr: bus.issue_address, pred: bus.issue_prediction};

    brq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .clear_i (do_miss),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        upd_valid_d   = do_pop;
        upd_address_d = upd_address_q;
        upd_result_d  = upd_result_q;
        mispredict_d  = do_miss;
        resolve_err_d = resolve_err_q || (bus.resolve_valid && (count == '0));
        if (do_pop) begin
            upd_address_d = head.addr;
            upd_result_d  = bus.resolve_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q   <= 1'b0;
            upd_address_q <= '0;
            upd_result_q  <= 1'b0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
        end else begin
            upd_valid_q   <= upd_valid_d;
            upd_address_q <= upd_address_d;
            upd_result_q  <= upd_result_d;
            mispredict_q  <= mispredict_d;
            resolve_err_q <= resolve_err_d;
        end
    end

`ifdef BRQ_STATS_EN
    logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (do_pop && !do_miss && (hit_q != '1)) hit_d  = hit_q + 1'b1;
        if (do_miss && (miss_q != '1))           miss_d = miss_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    assign bus.issue_ready = ready;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_address = upd_address_q;
    assign bus.upd_result  = upd_result_q;
    assign mispredict      = mispredict_q;
    assign resolve_err     = resolve_err_q;
    assign occupancy       = count;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed and random checks against a queue-based reference model
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.ADDR_W(1)) bus_a ();
    branch_resolve_queue_if #(.ADDR_W(1)) bus_b ();

    logic        misp_a, err_a, misp_b, err_b;
    logic [2:0]  occ_a, occ_b;
    logic [15:0] hit_a, miss_a;
    logic [1:0]  hit_b, miss_b;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .mispredict(misp_a), .resolve_err(err_a),
        .occupancy(occ_a), .hit_count(hit_a), .miss_count(miss_a)
    );

    branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .mispredict(misp_b), .resolve_err(err_b),
        .occupancy(occ_b), .hit_count(hit_b), .miss_count(miss_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit addr;
        bit pred;
    } ent_t;

    ent_t q[$];
    bit   m_err, m_uv, m_misp, m_ua, m_ur;
    int   m_hits, m_misses;

    function automatic int expect_cnt(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef BRQ_STATS_EN
        return (v > mx) ? mx : v;
`else
        return 0 * mx * v;
`endif
    endfunction

    task automatic check_all();
        check("occupancy_a", occ_a, q.size());
        check("occupancy_b", occ_b, q.size());
        check("issue_ready", bus_a.issue_ready, q.size() < DEPTH);
        check("upd_valid", bus_a.upd_valid, m_uv);
        check("mispredict", misp_a, m_misp);
        check("resolve_err", err_a, m_err);
        check("hit_a", hit_a, expect_cnt(m_hits, 16));
        check("miss_a", miss_a, expect_cnt(m_misses, 16));
        check("hit_b", hit_b, expect_cnt(m_hits, 2));
        check("miss_b", miss_b, expect_cnt(m_misses, 2));
        if (m_uv) begin
            check("upd_address", bus_a.upd_address, m_ua);
            check("upd_result", bus_a.upd_result, m_ur);
            check("upd_valid_b", bus_b.upd_valid, 1);
        end
    endtask

    task automatic drive(input bit iv, input bit a, input bit p, input bit rv, input bit rt);
        bus_a.issue_valid = iv; bus_a.issue_address = a; bus_a.issue_prediction = p;
        bus_a.resolve_valid = rv; bus_a.resolve_taken = rt;
        bus_b.issue_valid = iv; bus_b.issue_address = a; bus_b.issue_prediction = p;
        bus_b.resolve_valid = rv; bus_b.resolve_taken = rt;
    endtask

    // Expected state after the coming rising edge, from the queue rules alone.
    task automatic model_update(input bit iv, input bit a, input bit p, input bit rv, input bit rt);
        bit   accept;
        ent_t h;
        ent_t n;
        accept = (q.size() < DEPTH);
        m_uv = 0;
        m_misp = 0;
        if (rv && q.size() > 0) begin
            h = q.pop_front();
            m_uv = 1;
            m_ua = h.addr;
            m_ur = rt;
            if (h.pred != rt) begin
                m_misp = 1;
                m_misses++;
                q.delete();
            end else begin
                m_hits++;
            end
        end else if (rv) begin
            m_err = 1;
        end
        if (iv && accept && !m_misp) begin
            n.addr = a;
            n.pred = p;
            q.push_back(n);
        end
    endtask

    task automatic step(input bit iv, input bit a, input bit p, input bit rv, input bit rt);
        @(negedge clk);
        check_all();
        drive(iv, a, p, rv, rt);
        model_update(iv, a, p, rv, rt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        q.delete();
        m_err = 0; m_uv = 0; m_misp = 0; m_hits = 0; m_misses = 0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit iv, a, p, rv, rt;
        drive(0, 0, 0, 0, 0);
        do_reset();

        // single correct resolve
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);

        // mispredict on oldest of three flushes the rest, including a same-cycle issue
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);

        // fill, then issue+resolve while full: issue refused
        for (int i = 0; i < DEPTH; i++) step(1, i[0], 1, 0, 0);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);

        // reset with three entries held
        do_reset();

        // resolve on empty
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // narrow counter saturation
        for (int i = 0; i < 5; i++) begin
            step(1, i[0], 1, 0, 0);
            step(0, 0, 0, 1, 1);
        end
        step(0, 0, 0, 0, 0);
`ifdef BRQ_STATS_EN
        check("hit_sat_b", hit_b, 3);
`else
        check("hit_off_b", hit_b, 0);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            iv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 45);
            a  = 1'($urandom);
            p  = 1'($urandom);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) rt = q[0].pred;
            else rt = 1'($urandom);
            step(iv, a, p, rv, rt);
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
